trng_read_ctrl: RTL and testbench
=================================

// Module: trng_read_ctrl
// PURPOSE
//   Sequences the TRNG datapath between the entropy FIFO and the PS GPIO side.
//   After reset, enables the TRNG and discards the first WARMUP_WORDS FIFO words.
//   It then serves PS read requests with a 4-phase req/ack handshake.
//   Each request pops one FIFO word and presents it on ps_data.
//   Sits in the 50 MHz domain between top_trng/fifo64 and the AXI GPIO ports.
// PARAMETERS
//   WARMUP_WORDS  16      FIFO words discarded after reset (0 = no warm-up)
//   TIMEOUT_CYC   65535   wait cycles on empty FIFO before error-ack (>=1)
//   CNT_W         32      width of words_served counter
// PORTS
//   clk           in   1      50 MHz datapath clock
//   rst           in   1      asynchronous, active-low reset
//   trng_enable   out  1      enable to top_trng
//   fifo_empty    in   1      FIFO empty flag
//   fifo_rd_en    out  1      FIFO pop strobe; fifo_dout valid 1 cycle later
//   fifo_dout     in   64     FIFO read data
//   ps_req        in   1      PS request level (async to clk)
//   ps_ack        out  1      acknowledge level to PS
//   ps_data       out  64     captured random word, stable while ps_ack=1
//   ps_err        out  1      1 = last ack was a timeout (ps_data not updated)
//   ctrl_ready    out  1      1 = warm-up complete
//   words_served  out  CNT_W  count of words delivered to PS; wraps
// BEHAVIOUR
// - Reset (rst=0, async): state=WARM.
//     All outputs are 0 (trng_enable, fifo_rd_en, ps_ack, ps_data, ps_err, ctrl_ready, words_served).
//     The warm-up counter loads WARMUP_WORDS and the timeout counter is 0.
// - trng_enable is registered and goes to 1 on the first clk edge after rst deasserts.
// - ps_req passes through a 2-flop synchroniser; req_s is the synchronised level.
//     PS-side edges are seen 2-3 clk later.
// - fifo_rd_en is high exactly one cycle per pop; it never asserts while fifo_empty=1.
// - State machine: WARM, WARM_RD, WARM_WAIT, READY, RD, CAP, ACK.
//     WARM: warm-up count=0 -> READY.
//           Otherwise, fifo_empty=0 -> WARM_RD.
//     WARM_RD: fifo_rd_en=1 and decrement the warm-up count -> WARM_WAIT.
//     WARM_WAIT: the data is discarded -> WARM.
//       This gives one pop per 3 cycles and never reads a stale empty flag.
//     READY: ctrl_ready=1 from here on, until reset.
//       req_s=1 and fifo_empty=0 -> RD, clear the timeout counter.
//       req_s=1 and fifo_empty=1 -> increment the timeout counter.
//         When it reaches TIMEOUT_CYC -> ACK with ps_err=1; ps_data and words_served hold.
//       req_s=0 -> clear the timeout counter.
//     RD: fifo_rd_en=1 and ps_err<=0 -> CAP.
//     CAP: ps_data<=fifo_dout and words_served<=words_served+1 (mod 2^CNT_W) -> ACK.
//     ACK: ps_ack=1.
//       req_s=0 -> READY, with ps_ack=0 from the next cycle.
//       ps_data and ps_err hold until the next RD or timeout.
// - A request that drops during RD/CAP still completes the pop.
//     It enters ACK, then returns to READY after 1 cycle. The word is counted, not lost.
// - A request arriving during warm-up is not served until READY.
//     No timeout counting happens in warm-up states.
// - Latency from req_s rise to ps_ack rise, with the FIFO non-empty, is 3 cycles (READY->RD->CAP->ACK).
// - A new request is only accepted in READY, so each word is handed over in full 4-phase cycles.
// - Reset mid-transaction aborts immediately.
//     A pop already issued is lost (the FIFO is also reset by sys_rst).
// TESTING
// 1. WARMUP_WORDS=4, FIFO preloaded with 0x1..0x6.
//    -> Exactly 4 rd_en pulses with no ps_ack. ctrl_ready=1.
//    -> The first PS request returns ps_data=0x5, words_served=1.
// 2. READY with FIFO head 0xDEADBEEF_CAFEF00D; raise ps_req.
//    -> ps_ack rises 3 cycles after req_s, with that data and ps_err=0.
//    -> Drop ps_req -> ps_ack falls 1 cycle after req_s falls.
// 3. TIMEOUT_CYC=8, FIFO empty, raise ps_req.
//    -> After 8 wait cycles ps_ack=1, ps_err=1, ps_data unchanged, words_served unchanged, no rd_en.
// 4. 10 back-to-back 4-phase requests on a full FIFO.
//    -> 10 distinct words in FIFO order, words_served=10, exactly 10 rd_en pulses.
// 5. Pulse ps_req for 1 PS cycle during RD.
//    -> The word is captured, ps_ack pulses 1 cycle, and the next request returns the following word.
// 6. Assert rst while in ACK.
//    -> ps_ack, ps_data, ps_err, words_served and ctrl_ready clear asynchronously.
//    -> The warm-up restarts after release.

Source files
------------

// File: rtl/trng_read_ctrl_if.sv
// Signal bundle between the TRNG read controller, the entropy FIFO and the PS GPIO side.
// master = controller, slave = FIFO/PS environment.
interface trng_read_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             trng_enable;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [63:0]      fifo_dout;
  logic             ps_req;
  logic             ps_ack;
  logic [63:0]      ps_data;
  logic             ps_err;
  logic             ctrl_ready;
  logic [CNT_W-1:0] words_served;

  modport master (
    output trng_enable,
    output fifo_rd_en,
    output ps_ack,
    output ps_data,
    output ps_err,
    output ctrl_ready,
    output words_served,
    input  fifo_empty,
    input  fifo_dout,
    input  ps_req
  );

  modport slave (
    input  trng_enable,
    input  fifo_rd_en,
    input  ps_ack,
    input  ps_data,
    input  ps_err,
    input  ctrl_ready,
    input  words_served,
    output fifo_empty,
    output fifo_dout,
    output ps_req
  );
endinterface

// File: rtl/trng_read_ctrl.sv
// TRNG read controller: warm-up discard, then one FIFO word per
// 4-phase PS req/ack cycle, with timeout error-ack on an empty FIFO.
module trng_read_ctrl #(
  parameter int unsigned WARMUP_WORDS = 16,
  parameter int unsigned TIMEOUT_CYC  = 65535,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  trng_read_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    WARM,
    WARM_RD,
    WARM_WAIT,
    READY,
    RD,
    CAP,
    ACK
  } state_e;

  localparam logic [31:0] WarmInit = WARMUP_WORDS;
  localparam logic [31:0] TmoLast  = TIMEOUT_CYC - 1;

  state_e           state_q, state_d;
  logic [31:0]      warm_q, warm_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [63:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] served_q, served_d;
  logic             en_q;
  logic             req_meta_q, req_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WARM;
      warm_q     <= WarmInit;
      tmo_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      served_q   <= '0;
      en_q       <= 1'b0;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      served_q   <= served_d;
      en_q       <= 1'b1;
      req_meta_q <= bus.ps_req;
      req_s_q    <= req_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    err_d    = err_q;
    rdy_d    = rdy_q;
    served_d = served_q;
    unique case (state_q)
      WARM: begin
        if (warm_q == '0) begin
          state_d = READY;
          rdy_d   = 1'b1;
        end else if (!bus.fifo_empty) begin
          state_d = WARM_RD;
        end
      end
      WARM_RD: begin
        warm_d  = warm_q - 32'd1;
        state_d = WARM_WAIT;
      end
      // Popped word is dropped; re-checking empty only from WARM avoids a stale flag.
      WARM_WAIT: state_d = WARM;
      READY: begin
        if (!req_s_q) begin
          tmo_d = '0;
        end else if (!bus.fifo_empty) begin
          tmo_d   = '0;
          state_d = RD;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      RD: begin
        err_d   = 1'b0;
        state_d = CAP;
      end
      CAP: begin
        data_d   = bus.fifo_dout;
        served_d = served_q + 1'b1;
        state_d  = ACK;
      end
      ACK: begin
        if (!req_s_q) state_d = READY;
      end
      default: state_d = WARM;
    endcase
  end

  assign bus.trng_enable  = en_q;
  assign bus.fifo_rd_en   = (state_q == WARM_RD) || (state_q == RD);
  assign bus.ps_ack       = (state_q == ACK);
  assign bus.ps_data      = data_q;
  assign bus.ps_err       = err_q;
  assign bus.ctrl_ready   = rdy_q;
  assign bus.words_served = served_q;

endmodule

// File: tb/tb_trng_read_ctrl.sv
// Bench for trng_read_ctrl: FIFO model plus a word-order reference
// queue; each scenario task checks the DUT against it.
module tb_trng_read_ctrl;
  localparam int unsigned WU = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  trng_read_ctrl_if #(.CNT_W(CW)) bus ();

  trng_read_ctrl #(
    .WARMUP_WORDS(WU),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  // FIFO with registered read data; wr side owned by push, rd side by the monitor.
  logic [63:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops = 0;
  int          bad_rd = 0;
  logic [63:0] dout_q = '0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_dout  = dout_q;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) bad_rd <= bad_rd + 1;
      dout_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  // Reference: words in arrival order, count delivered, last delivered word.
  logic [63:0] mq[$];
  logic [CW-1:0] exp_served = '0;
  logic [63:0] last_word = '0;

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    mq.push_back(w);
  endtask

  function automatic logic [63:0] model_take();
    logic [63:0] w;
    w = mq.pop_front();
    exp_served = exp_served + 1'b1;
    last_word = w;
    return w;
  endfunction

  task automatic serve(output logic ok, output logic [63:0] d,
                       output logic e, output logic [CW-1:0] n);
    @(negedge clk);
    bus.ps_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.ps_ack) begin ok = 1'b1; break; end
    end
    d = bus.ps_data;
    e = bus.ps_err;
    n = bus.words_served;
    @(negedge clk);
    bus.ps_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.ps_ack) break;
    end
    if (bus.ps_ack) ok = 1'b0;
  endtask

  task automatic test_reset();
    bus.ps_req = 1'b0;
    rst = 1'b1;
    #5 rst = 1'b0;
    for (int i = 1; i <= 6; i++) push(64'(i));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.trng_enable, bus.fifo_rd_en, bus.ps_ack, bus.ps_err,
         bus.ctrl_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {bus.trng_enable,
               bus.fifo_rd_en, bus.ps_ack, bus.ps_err, bus.ctrl_ready});
    end
    checks++;
    if (bus.ps_data !== 64'h0 || bus.words_served !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%0d want 0/0",
               bus.ps_data, bus.words_served);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.trng_enable !== 1'b1) begin
      errors++;
      $display("FAIL trng_enable: got %b want 1", bus.trng_enable);
    end
  endtask

  task automatic test_warmup();
    logic ack_seen = 1'b0;
    logic ok, e;
    logic [63:0] d, w;
    logic [CW-1:0] n;
    for (int i = 0; i < 100; i++) begin
      if (bus.ps_ack) ack_seen = 1'b1;
      if (bus.ctrl_ready) break;
      @(posedge clk); #1;
    end
    checks++;
    if (bus.ctrl_ready !== 1'b1 || ack_seen !== 1'b0) begin
      errors++;
      $display("FAIL warmup_ready: ready=%b ack_seen=%b want 1/0",
               bus.ctrl_ready, ack_seen);
    end
    checks++;
    if (pops !== int'(WU)) begin
      errors++;
      $display("FAIL warmup_pops: got %0d want %0d", pops, WU);
    end
    repeat (WU) void'(mq.pop_front());
    serve(ok, d, e, n);
    w = model_take();
    checks++;
    if (!ok || d !== w || e !== 1'b0 || n !== exp_served) begin
      errors++;
      $display("FAIL first_req: ok=%b data=%h err=%b n=%0d want %h/0/%0d",
               ok, d, e, n, w, exp_served);
    end
  endtask

  task automatic test_latency();
    logic ok, e;
    logic [63:0] d, w;
    logic [CW-1:0] n;
    int cyc;
    serve(ok, d, e, n);
    w = model_take();
    checks++;
    if (!ok || d !== w || n !== exp_served) begin
      errors++;
      $display("FAIL drain_req: ok=%b data=%h n=%0d want %h/%0d",
               ok, d, n, w, exp_served);
    end
    push(64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    bus.ps_req = 1'b1;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ps_ack) break;
    end
    w = model_take();
    // 2 edges to reach req_s, then 3 for READY->RD->CAP->ACK.
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL ack_latency: got %0d want 5 edges", cyc);
    end
    checks++;
    if (bus.ps_data !== w || bus.ps_err !== 1'b0 ||
        bus.words_served !== exp_served) begin
      errors++;
      $display("FAIL latency_data: data=%h err=%b n=%0d want %h/0/%0d",
               bus.ps_data, bus.ps_err, bus.words_served, w, exp_served);
    end
    @(negedge clk);
    bus.ps_req = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!bus.ps_ack) break;
    end
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL ack_fall: got %0d want 3 edges", cyc);
    end
  endtask

  task automatic test_timeout();
    int p0, cyc;
    p0 = pops;
    @(negedge clk);
    bus.ps_req = 1'b1;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ps_ack) break;
    end
    // 2 synchroniser edges plus TO wait cycles.
    checks++;
    if (cyc !== 2 + int'(TO) || bus.ps_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ack: edges=%0d err=%b want %0d/1",
               cyc, bus.ps_err, 2 + TO);
    end
    checks++;
    if (bus.ps_data !== last_word || bus.words_served !== exp_served ||
        pops !== p0) begin
      errors++;
      $display("FAIL timeout_hold: data=%h n=%0d pops=%0d want %h/%0d/%0d",
               bus.ps_data, bus.words_served, pops, last_word, exp_served, p0);
    end
    @(negedge clk);
    bus.ps_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.ps_ack) break;
    end
  endtask

  task automatic test_back_to_back();
    logic ok, e;
    logic [63:0] d, w;
    logic [CW-1:0] n;
    int p0;
    for (int i = 0; i < 10; i++)
      push({32'($urandom()), 24'($urandom()), 8'(i)});
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      serve(ok, d, e, n);
      w = model_take();
      checks++;
      if (!ok || d !== w || e !== 1'b0 || n !== exp_served) begin
        errors++;
        $display("FAIL b2b_%0d: ok=%b data=%h err=%b n=%0d want %h/0/%0d",
                 i, ok, d, e, n, w, exp_served);
      end
    end
    checks++;
    if (pops - p0 !== 10) begin
      errors++;
      $display("FAIL b2b_pops: got %0d want 10", pops - p0);
    end
  endtask

  task automatic test_pulse();
    logic ok, e;
    logic [63:0] d, w, cap;
    logic [CW-1:0] n, ncap;
    int hi;
    push({32'($urandom()), 32'h0000_0A01});
    push({32'($urandom()), 32'h0000_0A02});
    @(negedge clk);
    bus.ps_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.fifo_rd_en) break;
    end
    bus.ps_req = 1'b0;
    hi = 0;
    cap = '0;
    ncap = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ps_ack) begin
        hi++;
        cap = bus.ps_data;
        ncap = bus.words_served;
      end
    end
    w = model_take();
    checks++;
    if (hi !== 1 || cap !== w || ncap !== exp_served) begin
      errors++;
      $display("FAIL pulse_req: ack_cycles=%0d data=%h n=%0d want 1/%h/%0d",
               hi, cap, ncap, w, exp_served);
    end
    serve(ok, d, e, n);
    w = model_take();
    checks++;
    if (!ok || d !== w || n !== exp_served) begin
      errors++;
      $display("FAIL pulse_next: ok=%b data=%h n=%0d want %h/%0d",
               ok, d, n, w, exp_served);
    end
  endtask

  task automatic test_reset_in_ack();
    logic ok, e, got;
    logic [63:0] d, w;
    logic [CW-1:0] n;
    int p0;
    for (int i = 0; i < 6; i++) push({32'($urandom()), 32'(16'hB000 + i)});
    @(negedge clk);
    bus.ps_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.ps_ack) begin got = 1'b1; break; end
    end
    void'(model_take());
    #3 rst = 1'b0;
    #1;
    checks++;
    if (!got || {bus.ps_ack, bus.ps_err, bus.ctrl_ready} !== 3'b0 ||
        bus.ps_data !== 64'h0 || bus.words_served !== '0) begin
      errors++;
      $display("FAIL async_rst: acked=%b flags=%b data=%h n=%0d want 1/000/0/0",
               got, {bus.ps_ack, bus.ps_err, bus.ctrl_ready},
               bus.ps_data, bus.words_served);
    end
    bus.ps_req = 1'b0;
    exp_served = '0;
    @(negedge clk);
    p0 = pops;
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.ctrl_ready) break;
    end
    checks++;
    if (bus.ctrl_ready !== 1'b1 || pops - p0 !== int'(WU)) begin
      errors++;
      $display("FAIL rewarm: ready=%b pops=%0d want 1/%0d",
               bus.ctrl_ready, pops - p0, WU);
    end
    repeat (WU) void'(mq.pop_front());
    serve(ok, d, e, n);
    w = model_take();
    checks++;
    if (!ok || d !== w || e !== 1'b0 || n !== exp_served) begin
      errors++;
      $display("FAIL post_rst_req: ok=%b data=%h err=%b n=%0d want %h/0/%0d",
               ok, d, e, n, w, exp_served);
    end
  endtask

  task automatic test_no_empty_pop();
    checks++;
    if (bad_rd !== 0) begin
      errors++;
      $display("FAIL empty_pop: got %0d want 0", bad_rd);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_latency();
    test_timeout();
    test_back_to_back();
    test_pulse();
    test_reset_in_ack();
    test_no_empty_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
